// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants the single Common Data Bus to one of four execution
// units (0 = int, 1 = ld, 2 = mul, 3 = div) and registers the winner onto the CDB.
// Requests younger than a mispredicted branch are masked during the flush cycle.
// A per-requester wait counter promotes any requester that has waited
// STARVE_LIMIT cycles to top priority.
// Build option: define CDB_RR_EN for a round-robin base policy. When it is
// undefined, the base policy is fixed priority div > mul > ld > int.
module cdb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned DWIDTH       = 32
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic [3:0]             req_val,
  input  logic [3:0][4:0]        req_robtag,
  input  logic [3:0][5:0]        req_phytag,
  input  logic [3:0]             req_regwrite,
  input  logic [3:0][DWIDTH-1:0] req_data,
  output logic [3:0]             req_gnt,
  input  logic [4:0]             rob_rdptr,
  input  logic                   flush_val,
  input  logic [4:0]             flush_robtag,
  output logic                   cdb_val,
  output logic [4:0]             cdb_robtag,
  output logic [5:0]             cdb_phytag,
  output logic                   cdb_regwrite,
  output logic [DWIDTH-1:0]      cdb_data
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [4:0] flush_depth;
  logic [4:0] depth [4];
  logic [3:0] masked;
  logic [3:0] eligible;
  logic [3:0] starved;
  logic [3:0] gnt_pick;
  logic [1:0] win_idx;
  logic [7:0] wait_cnt [4];

`ifdef CDB_RR_EN
  logic [1:0] rr_ptr;
  logic [7:0] rot_dbl;
  logic [3:0] rot;
  logic [3:0] rot_pick;
  logic [7:0] back_dbl;
`endif

  // Age relative to the ROB head; mask requests younger than the flushing branch.
  always_comb begin
    flush_depth = flush_robtag - rob_rdptr;
    masked      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      depth[i]  = req_robtag[i] - rob_rdptr;
      masked[i] = flush_val && (depth[i] > flush_depth);
    end
  end

  assign eligible = req_val & ~masked;

  // Eligible requesters whose wait counter has saturated.
  always_comb begin
    starved = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      starved[i] = eligible[i] && (wait_cnt[i] == LIMIT);
    end
  end

  // Grant selection: starved requesters first (lowest index), then base policy.
  always_comb begin
    gnt_pick = '0;
`ifdef CDB_RR_EN
    // Rotate so rr_ptr lands on bit 0, take the lowest set bit, rotate back.
    rot_dbl  = {eligible, eligible} >> rr_ptr;
    rot      = rot_dbl[3:0];
    rot_pick = rot & (~rot + 4'd1);
    back_dbl = {rot_pick, rot_pick} << rr_ptr;
`endif
    if (|starved) begin
      gnt_pick = starved & (~starved + 4'd1);
    end else begin
`ifdef CDB_RR_EN
      gnt_pick = back_dbl[7:4];
`else
      for (int unsigned i = 0; i < 4; i++) begin
        if (eligible[i]) begin
          gnt_pick = 4'b0001 << i;
        end
      end
`endif
    end
  end

  assign req_gnt = rst_b ? gnt_pick : '0;

  // Encode the winner index for the payload mux and pointer update.
  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (gnt_pick[i]) begin
        win_idx = 2'(i);
      end
    end
  end

  // Starvation counters: count while waiting, clear on grant or idle, saturate.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int unsigned i = 0; i < 4; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (req_gnt[i] || !req_val[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != LIMIT) begin
          wait_cnt[i] <= wait_cnt[i] + 8'd1;
        end
      end
    end
  end

`ifdef CDB_RR_EN
  // Round-robin pointer moves past every winner, starved winners included.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rr_ptr <= '0;
    end else if (|req_gnt) begin
      rr_ptr <= win_idx + 2'd1;
    end
  end
`endif

  // CDB register: load the winner's payload; hold the payload when idle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cdb_val      <= 1'b0;
      cdb_robtag   <= '0;
      cdb_phytag   <= '0;
      cdb_regwrite <= 1'b0;
      cdb_data     <= '0;
    end else begin
      cdb_val <= |req_gnt;
      if (|req_gnt) begin
        cdb_robtag   <= req_robtag[win_idx];
        cdb_phytag   <= req_phytag[win_idx];
        cdb_regwrite <= req_regwrite[win_idx];
        cdb_data     <= req_data[win_idx];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: self-checking bench for cdb_arbiter. Two instances share
// the request inputs: dut 0 uses STARVE_LIMIT=8 and dut 1 uses STARVE_LIMIT=2.
// A reference model predicts each grant and pushes the expected CDB contents
// to a queue. The next clock edge pops and compares them.
module tb_cdb_arbiter;

  localparam int LIM_A = 8;
  localparam int LIM_B = 2;

  typedef struct packed {
    logic        val;
    logic [4:0]  rt;
    logic [5:0]  pt;
    logic        rw;
    logic [31:0] d;
  } cdb_t;

  logic              clk;
  logic              rst_b;
  logic [3:0]        req_val;
  logic [3:0][4:0]   req_robtag;
  logic [3:0][5:0]   req_phytag;
  logic [3:0]        req_regwrite;
  logic [3:0][31:0]  req_data;
  logic [4:0]        rob_rdptr;
  logic              flush_val;
  logic [4:0]        flush_robtag;

  logic [3:0]  gnt_o          [2];
  logic        cdb_val_o      [2];
  logic [4:0]  cdb_robtag_o   [2];
  logic [5:0]  cdb_phytag_o   [2];
  logic        cdb_regwrite_o [2];
  logic [31:0] cdb_data_o     [2];

  int total = 0;
  int bad   = 0;

  cdb_t       sbq [$];
  int         m_wait [2][4];
  int         m_rr   [2];
  cdb_t       m_hold [2];
  logic [3:0] last_gnt [2];

  cdb_arbiter #(.STARVE_LIMIT(LIM_A), .DWIDTH(32)) dut0 (
    .clk(clk), .rst_b(rst_b), .req_val(req_val), .req_robtag(req_robtag),
    .req_phytag(req_phytag), .req_regwrite(req_regwrite), .req_data(req_data),
    .req_gnt(gnt_o[0]), .rob_rdptr(rob_rdptr), .flush_val(flush_val),
    .flush_robtag(flush_robtag), .cdb_val(cdb_val_o[0]), .cdb_robtag(cdb_robtag_o[0]),
    .cdb_phytag(cdb_phytag_o[0]), .cdb_regwrite(cdb_regwrite_o[0]), .cdb_data(cdb_data_o[0])
  );

  cdb_arbiter #(.STARVE_LIMIT(LIM_B), .DWIDTH(32)) dut1 (
    .clk(clk), .rst_b(rst_b), .req_val(req_val), .req_robtag(req_robtag),
    .req_phytag(req_phytag), .req_regwrite(req_regwrite), .req_data(req_data),
    .req_gnt(gnt_o[1]), .rob_rdptr(rob_rdptr), .flush_val(flush_val),
    .flush_robtag(flush_robtag), .cdb_val(cdb_val_o[1]), .cdb_robtag(cdb_robtag_o[1]),
    .cdb_phytag(cdb_phytag_o[1]), .cdb_regwrite(cdb_regwrite_o[1]), .cdb_data(cdb_data_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // One cycle: model and grant check at negedge, CDB check just after posedge.
  task automatic tick();
    cdb_t ent, got;
    int fd, rd, sel, j, lim;
    bit found;
    logic [3:0] elig, eg;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      lim = (d == 0) ? LIM_A : LIM_B;
      eg  = '0;
      if (!rst_b) begin
        for (int i = 0; i < 4; i++) m_wait[d][i] = 0;
        m_rr[d]   = 0;
        m_hold[d] = '0;
        sbq.push_back('0);
      end else begin
        fd = (int'(flush_robtag) - int'(rob_rdptr) + 32) % 32;
        for (int i = 0; i < 4; i++) begin
          elig[i] = req_val[i];
          rd = (int'(req_robtag[i]) - int'(rob_rdptr) + 32) % 32;
          if (flush_val && rd > fd) elig[i] = 1'b0;
        end
        found = 1'b0;
        sel   = 0;
        for (int i = 0; i < 4; i++) begin
          if (!found && elig[i] && m_wait[d][i] == lim) begin
            sel = i; found = 1'b1;
          end
        end
`ifdef CDB_RR_EN
        for (int k = 0; k < 4; k++) begin
          j = (m_rr[d] + k) % 4;
          if (!found && elig[j]) begin
            sel = j; found = 1'b1;
          end
        end
`else
        for (int i = 3; i >= 0; i--) begin
          if (!found && elig[i]) begin
            sel = i; found = 1'b1;
          end
        end
`endif
        if (found) begin
          eg[sel]      = 1'b1;
          m_rr[d]      = (sel + 1) % 4;
          m_hold[d].val = 1'b1;
          m_hold[d].rt = req_robtag[sel];
          m_hold[d].pt = req_phytag[sel];
          m_hold[d].rw = req_regwrite[sel];
          m_hold[d].d  = req_data[sel];
        end
        for (int i = 0; i < 4; i++) begin
          if (req_val[i] && !eg[i])
            m_wait[d][i] = (m_wait[d][i] < lim) ? m_wait[d][i] + 1 : lim;
          else
            m_wait[d][i] = 0;
        end
        ent     = m_hold[d];
        ent.val = found;
        sbq.push_back(ent);
      end
      last_gnt[d] = gnt_o[d];
      total++;
      if (gnt_o[d] !== eg) begin
        bad++;
        $display("FAIL sb_gnt dut%0d got=%b exp=%b", d, gnt_o[d], eg);
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_empty dut%0d got=empty exp=entry", d);
      end else begin
        ent = sbq.pop_front();
        got.val = cdb_val_o[d];
        got.rt  = cdb_robtag_o[d];
        got.pt  = cdb_phytag_o[d];
        got.rw  = cdb_regwrite_o[d];
        got.d   = cdb_data_o[d];
        if (got !== ent) begin
          bad++;
          $display("FAIL sb_cdb dut%0d got=%b/%0d/%0d/%b/%h exp=%b/%0d/%0d/%b/%h", d,
                   got.val, got.rt, got.pt, got.rw, got.d, ent.val, ent.rt, ent.pt, ent.rw, ent.d);
        end
      end
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] rt, input logic [5:0] pt,
                         input logic rw, input logic [31:0] d);
    req_robtag[i]   = rt;
    req_phytag[i]   = pt;
    req_regwrite[i] = rw;
    req_data[i]     = d;
  endtask

  task automatic do_reset();
    req_val   = '0;
    flush_val = 1'b0;
    #1 rst_b  = 1'b0;
    tick();
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    rob_rdptr = '0; flush_val = 1'b0; flush_robtag = '0;
    for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 6'(i + 1), 1'b1, 32'h1000 + i);
    req_val = 4'b1111;
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (last_gnt[d] !== 4'b0000) begin bad++; $display("FAIL reset_gnt dut%0d got=%b exp=0000", d, last_gnt[d]); end
      total++;
      if ({cdb_val_o[d], cdb_robtag_o[d], cdb_phytag_o[d], cdb_regwrite_o[d], cdb_data_o[d]} !== '0) begin
        bad++; $display("FAIL reset_cdb dut%0d got=%b/%0d/%h exp=0/0/0", d, cdb_val_o[d], cdb_robtag_o[d], cdb_data_o[d]);
      end
    end
    tick();
    rst_b   = 1'b1;
    req_val = '0;
    tick();
  endtask

  task automatic test_single();
    set_req(0, 5'd5, 6'd12, 1'b1, 32'hDEADBEEF);
    req_val = 4'b0001;
    tick();
    total++;
    if (last_gnt[0] !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b exp=0001", last_gnt[0]); end
    total++;
    if (cdb_val_o[0] !== 1'b1 || cdb_robtag_o[0] !== 5'd5 || cdb_phytag_o[0] !== 6'd12 ||
        cdb_data_o[0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_cdb got=%b/%0d/%0d/%h exp=1/5/12/deadbeef",
               cdb_val_o[0], cdb_robtag_o[0], cdb_phytag_o[0], cdb_data_o[0]);
    end
    req_val = '0;
    tick();
    total++;
    if (cdb_val_o[0] !== 1'b0 || cdb_robtag_o[0] !== 5'd5) begin
      bad++; $display("FAIL single_idle got=%b/%0d exp=0/5", cdb_val_o[0], cdb_robtag_o[0]);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] g [12];
    int first_int;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 5'(10 + i), 6'(20 + i), 1'(i % 2), 32'hA000 + i);
    req_val = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      tick();
      g[c] = last_gnt[0];
    end
    req_val = '0;
`ifdef CDB_RR_EN
    for (int c = 0; c < 12; c++) begin
      total++;
      if (g[c] !== (4'b0001 << (c % 4))) begin
        bad++; $display("FAIL rr_rotate cycle%0d got=%b exp=%b", c, g[c], 4'b0001 << (c % 4));
      end
    end
`else
    total++;
    if (g[0] !== 4'b1000) begin bad++; $display("FAIL fixed_first got=%b exp=1000", g[0]); end
    first_int = -1;
    for (int c = 11; c >= 0; c--) if (g[c][0]) first_int = c;
    total++;
    if (first_int < 0 || first_int > LIM_A) begin
      bad++; $display("FAIL int_starve got=cycle%0d exp=<=cycle%0d", first_int, LIM_A);
    end
`endif
    tick();
  endtask

  task automatic test_flush_mask();
    rob_rdptr    = 5'd30;
    flush_robtag = 5'd1;
    flush_val    = 1'b1;
    set_req(1, 5'd0, 6'd33, 1'b1, 32'h0000_1111);
    set_req(2, 5'd4, 6'd34, 1'b1, 32'h0000_2222);
    req_val = 4'b0110;
    tick();
    total++;
    if (last_gnt[0] !== 4'b0010) begin bad++; $display("FAIL flush_mask got=%b exp=0010", last_gnt[0]); end
    total++;
    if (cdb_robtag_o[0] !== 5'd0 || cdb_data_o[0] !== 32'h0000_1111) begin
      bad++; $display("FAIL flush_cdb got=%0d/%h exp=0/00001111", cdb_robtag_o[0], cdb_data_o[0]);
    end
    flush_val = 1'b0;
    req_val   = 4'b0100;
    tick();
    total++;
    if (last_gnt[0] !== 4'b0100) begin bad++; $display("FAIL flush_after got=%b exp=0100", last_gnt[0]); end
    req_val = '0;
    tick();
  endtask

  task automatic test_flush_equal();
    rob_rdptr    = 5'd3;
    flush_robtag = 5'd7;
    flush_val    = 1'b1;
    set_req(0, 5'd7, 6'd40, 1'b0, 32'h7777_0000);
    set_req(3, 5'd8, 6'd41, 1'b1, 32'h8888_0000);
    req_val = 4'b1001;
    tick();
    total++;
    if (last_gnt[0] !== 4'b0001) begin bad++; $display("FAIL flush_equal got=%b exp=0001", last_gnt[0]); end
    total++;
    if (cdb_robtag_o[0] !== 5'd7 || cdb_regwrite_o[0] !== 1'b0) begin
      bad++; $display("FAIL flush_equal_cdb got=%0d/%b exp=7/0", cdb_robtag_o[0], cdb_regwrite_o[0]);
    end
    flush_val = 1'b0;
    req_val   = 4'b1000;
    tick();
    total++;
    if (last_gnt[0] !== 4'b1000) begin bad++; $display("FAIL flush_release got=%b exp=1000", last_gnt[0]); end
    req_val = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(1, 5'd12, 6'd50, 1'b1, 32'hCAFE_F00D);
    req_val = 4'b0010;
    tick();
    total++;
    if (cdb_val_o[0] !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b exp=1", cdb_val_o[0]); end
    req_val = '0;
    #1 rst_b = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (cdb_val_o[d] !== 1'b0 || cdb_data_o[d] !== 32'h0) begin
        bad++; $display("FAIL mid_async dut%0d got=%b/%h exp=0/0", d, cdb_val_o[d], cdb_data_o[d]);
      end
    end
    tick();
    rst_b = 1'b1;
    set_req(3, 5'd20, 6'd51, 1'b1, 32'h1234_5678);
    req_val = 4'b1000;
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (last_gnt[d] !== 4'b1000) begin bad++; $display("FAIL mid_first dut%0d got=%b exp=1000", d, last_gnt[d]); end
    end
    req_val = '0;
    tick();
  endtask

  task automatic test_starvation();
    logic [3:0] g [4];
    logic [3:0] exp_g [4];
`ifdef CDB_RR_EN
    exp_g = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
`else
    exp_g = '{4'b1000, 4'b1000, 4'b0001, 4'b1000};
`endif
    do_reset();
    set_req(0, 5'd1, 6'd60, 1'b1, 32'h0000_00AA);
    set_req(3, 5'd2, 6'd61, 1'b1, 32'h0000_00BB);
    req_val = 4'b1001;
    for (int c = 0; c < 4; c++) begin
      tick();
      g[c] = last_gnt[1];
    end
    req_val = '0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (g[c] !== exp_g[c]) begin
        bad++; $display("FAIL starve_cycle%0d got=%b exp=%b", c + 1, g[c], exp_g[c]);
      end
    end
    tick();
  endtask

  initial begin
    req_val      = '0;
    req_robtag   = '0;
    req_phytag   = '0;
    req_regwrite = '0;
    req_data     = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_flush_mask();
    test_flush_equal();
    test_reset_mid();
    test_starvation();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the single Common Data Bus (CDB) between four execution-unit requesters: integer ALU, load, multiplier and divider. It grants at most one requester per cycle and registers the winner onto the CDB, which feeds the ROB completion logic, the reservation stations and the physical register file. Requests younger than a mispredicted branch are masked during the flush cycle. A starvation guard bounds the wait time of every requester.

## Interface
- STARVE_LIMIT, 8: wait cycles after which a pending requester is promoted to top priority (range 2..255).
- DWIDTH, 32: CDB data width.
- clk  input  1  clock.
- rst_b  input  1  reset; asynchronous, active-low.
- req_val  input  4  per-requester valid. Index 0 = int, 1 = ld, 2 = mul, 3 = div.
- req_robtag  input  4x5  ROB tag of each request.
- req_phytag  input  4x6  destination physical register of each request.
- req_regwrite  input  4  the request writes a register.
- req_data  input  4xDWIDTH  result data (for stores, the store address).
- req_gnt  output  4  one-hot grant, combinational, same cycle as the request.
- rob_rdptr  input  5  ROB head pointer, used for age computation.
- flush_val  input  1  mispredict flush, 1-cycle pulse.
- flush_robtag  input  5  ROB tag of the mispredicted branch.
- cdb_val  output  1  CDB valid (registered).
- cdb_robtag  output  5  CDB ROB tag (registered).
- cdb_phytag  output  6  CDB physical tag (registered).
- cdb_regwrite  output  1  CDB register-write flag (registered).
- cdb_data  output  DWIDTH  CDB data (registered).

## Operation
- **Handshake:** a requester holds req_val and its payload stable until req_gnt[i]=1. The payload is consumed in the grant cycle. The requester may present a new request in the next cycle.
- **Age:** depth(t) = (t − rob_rdptr) mod 32, 5-bit unsigned.
- **Flush masking:** when flush_val=1, requester i is eligible only if depth(req_robtag[i]) ≤ depth(flush_robtag).
  - A request whose tag equals flush_robtag is eligible.
  - Masked requesters receive no grant. Dropping their request is the requester's job.
- **Eligibility:** eligible = req_val & ~masked.
- **Starvation counters:** wait_cnt[i] is 8 bits per requester.
  - Increments while req_val[i]=1 and req_gnt[i]=0.
  - Clears on grant or when req_val[i]=0.
  - Saturates at STARVE_LIMIT.
- **Grant priority:**
  1. Any eligible requester with wait_cnt = STARVE_LIMIT wins. Ties go to the lowest index.
  2. Otherwise the base policy applies (see Configuration).
- **CDB register load:** on any grant, the CDB registers load the winner's payload and cdb_val←1. With no grant, cdb_val←0 and the payload registers hold their value.
- **Invariant:** req_gnt is one-hot or zero; it is never asserted for an ineligible requester.

## Timing
- Request presented in cycle N and granted in cycle N → cdb_* valid during cycle N+1 only. Arbitration-to-bus latency is 1 cycle.
- Throughput: one CDB transfer per cycle; back-to-back grants are allowed.
- A flush in cycle N does not retract cdb_val already driven in cycle N. The masking applies to the grant made in cycle N, i.e. to bus cycle N+1.
- Wrap-around: depth arithmetic is modulo 32, so tags on either side of the 31→0 boundary order correctly relative to rob_rdptr.
- Reset, asserted asynchronously (also mid-transfer):
  - Outputs: cdb_val=0, cdb_robtag=0, cdb_phytag=0, cdb_regwrite=0, cdb_data=0.
  - State: all wait_cnt=0, round-robin pointer=0.
  - req_gnt=0 while rst_b=0.
- First grant is possible in the first cycle after rst_b deasserts.

## Configuration
- CDB_RR_EN defined: the base policy is round-robin.
  - rr_ptr is a 2-bit pointer; the search starts at rr_ptr and proceeds by increasing index, wrapping.
  - After any grant to index k, rr_ptr←k+1 mod 4.
  - This also applies to grants won through the starvation rule.
- CDB_RR_EN undefined: the base policy is fixed priority div(3) > mul(2) > ld(1) > int(0).
  - rr_ptr is not implemented.
  - The starvation rule is the only fairness mechanism.

## Test plan
- **Single request:** req_val=4'b0001, robtag=5, data=0xDEADBEEF, phytag=12 → req_gnt=0001 in the same cycle; next cycle cdb_val=1, cdb_robtag=5, cdb_data=0xDEADBEEF, cdb_phytag=12; the cycle after that cdb_val=0.
- **Simultaneous requests:** all four requesters request continuously.
  - CDB_RR_EN defined: grants rotate 0,1,2,3,0…
  - CDB_RR_EN undefined: div is granted first; int is granted no later than STARVE_LIMIT+1 cycles after its first request.
- **Flush mask:** rob_rdptr=30, flush_robtag=1 (depth 3); ld tag 0 (depth 2) and mul tag 4 (depth 6) request with flush_val=1 → only ld is granted. mul is never granted in that cycle even under fixed priority.
- **Flush equal tag:** flush_robtag=7 and int request with tag 7 under flush → granted.
- **Reset mid-operation:** assert rst_b low in the cycle after a grant → cdb_val=0 immediately (asynchronous). After release with req_val=1000 → grant in the first cycle and all counters restart from 0.
- **Starvation saturation:** in fixed mode, STARVE_LIMIT=2, div and int held valid → int is granted in cycle 3, then div resumes winning.
